// File: rtl/hidden_wires_arbiter.sv
// Round-robin arbiter sharing one hidden-wires side channel between NUM_REQ requesters.
// One transaction in flight, held on the channel until hw_ack or an optional timeout.
module hidden_wires_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*64-1:0] req_address,
  input  logic [NUM_REQ*32-1:0] req_data,
  input  logic [NUM_REQ*64-1:0] req_data64,
  output logic [63:0]          hw_address,
  output logic [31:0]          hw_data,
  output logic [63:0]          hw_data64,
  output logic                 hw_enable,
  input  logic                 hw_ack,
  output logic [ID_W-1:0]      grant_id,
  output logic                 err_timeout,
  output logic [ID_W-1:0]      err_id,
  input  logic                 err_clear
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   last_grant_reg;
  logic [TW-1:0]     timer_reg;
  logic [63:0]       hw_address_reg;
  logic [31:0]       hw_data_reg;
  logic [63:0]       hw_data64_reg;
  logic [ID_W-1:0]   grant_id_reg;
  logic              err_timeout_reg;
  logic [ID_W-1:0]   err_id_reg;

  logic [63:0]       addr_arr   [NUM_REQ];
  logic [31:0]       data_arr   [NUM_REQ];
  logic [63:0]       data64_arr [NUM_REQ];
  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic              transfer;
  logic              timeout_hit;
  logic              err_set;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]   = req_address[gi*64 +: 64];
      assign data_arr[gi]   = req_data[gi*32 +: 32];
      assign data64_arr[gi] = req_data64[gi*64 +: 64];
    end
  endgenerate

  // Walk offsets from farthest to nearest so the requester closest after last_grant wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant_reg) + k) % NUM_REQ]) begin
        winner    = ID_W'((int'(last_grant_reg) + k) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && any_valid)
      req_ready[winner] = 1'b1;
  end

  assign transfer    = (state_reg == IDLE) && any_valid;
  assign timeout_hit = (TIMEOUT != 0) && (timer_reg == TIMER_LAST);
  assign err_set     = (state_reg == BUSY) && !hw_ack && timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (any_valid) state_next = BUSY;
      BUSY: if (hw_ack || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg  <= ID_W'(NUM_REQ - 1);
      timer_reg       <= '0;
      hw_address_reg  <= '0;
      hw_data_reg     <= '0;
      hw_data64_reg   <= '0;
      grant_id_reg    <= '0;
      err_timeout_reg <= 1'b0;
      err_id_reg      <= '0;
    end else begin
      if (transfer) begin
        hw_address_reg <= addr_arr[winner];
        hw_data_reg    <= data_arr[winner];
        hw_data64_reg  <= data64_arr[winner];
        grant_id_reg   <= winner;
        last_grant_reg <= winner;
        timer_reg      <= '0;
      end else if (state_reg == BUSY && timer_reg != '1) begin
        timer_reg <= timer_reg + TW'(1);
      end

      // A clear in the same cycle as a new timeout wins; that error is dropped.
      if (err_clear) begin
        err_timeout_reg <= 1'b0;
        err_id_reg      <= '0;
      end else if (err_set && !err_timeout_reg) begin
        err_timeout_reg <= 1'b1;
        err_id_reg      <= grant_id_reg;
      end
    end
  end

  assign hw_address  = hw_address_reg;
  assign hw_data     = hw_data_reg;
  assign hw_data64   = hw_data64_reg;
  assign hw_enable   = (state_reg == BUSY);
  assign grant_id    = grant_id_reg;
  assign err_timeout = err_timeout_reg;
  assign err_id      = err_id_reg;

endmodule
